// File: rtl/pipe_adder_seg_pkg.sv
// Shared definitions for the segmented pipelined adder family.
//   op_e        : encoding of the sub control (add / subtract)
//   calc_stages : number of pipeline stages for a given width and segment size
//   seg_fits    : legality check, width must be a whole number of segments
package pipe_adder_seg_pkg;

  typedef enum logic {
    OpAdd = 1'b0,
    OpSub = 1'b1
  } op_e;

  function automatic int unsigned calc_stages(int unsigned n, int unsigned seg);
    return n / seg;
  endfunction

  function automatic bit seg_fits(int unsigned n, int unsigned seg);
    return (seg != 0) && ((n % seg) == 0);
  endfunction

endpackage

// File: rtl/adder_seg_stage.sv
// One registered SEG-bit add-with-carry stage.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   en         : pipeline advance; the stage holds its contents when low
//   valid_in   : beat valid entering this stage
//   a_seg      : operand A segment
//   b_seg      : operand B segment (already inverted for subtraction)
//   c_in       : carry from the previous stage (or the entry carry)
//   valid_out  : registered beat valid
//   s_seg      : registered segment sum
//   c_out      : registered carry out of this segment
module adder_seg_stage #(
  parameter int unsigned SEG = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           valid_in,
  input  logic [SEG-1:0] a_seg,
  input  logic [SEG-1:0] b_seg,
  input  logic           c_in,
  output logic           valid_out,
  output logic [SEG-1:0] s_seg,
  output logic           c_out
);

  logic [SEG:0]   add_w;
  logic           valid_d, valid_q;
  logic [SEG-1:0] s_d, s_q;
  logic           c_d, c_q;

  assign add_w = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, c_in};

  always_comb begin
    valid_d = valid_q;
    s_d     = s_q;
    c_d     = c_q;
    if (en) begin
      valid_d = valid_in;
      s_d     = add_w[SEG-1:0];
      c_d     = add_w[SEG];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
    end else begin
      valid_q <= valid_d;
      s_q     <= s_d;
      c_q     <= c_d;
    end
  end

  assign valid_out = valid_q;
  assign s_seg     = s_q;
  assign c_out     = c_q;

endmodule

// File: rtl/pipe_adder_seg.sv
// Pipelined N-bit add/subtract unit, carry chain registered every SEG bits.
// One segment is resolved per stage; STAGES = N/SEG cycles of latency, one beat per cycle.
// Ports:
//   clk, reset          : clock and asynchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready = pipeline may advance)
//   a, b, cin, sub      : operands; sub=0 a+b+cin, sub=1 a-b-cin
//   out_valid/out_ready : result handshake
//   sum                 : result modulo 2^N (saturated when enabled)
//   c_out               : add: carry out; sub: 1 = no borrow
//   ovf                 : signed overflow
// Build option: define PIPE_ADDER_SAT_EN for unsigned saturation of sum in the last stage.
module pipe_adder_seg
  import pipe_adder_seg_pkg::*;
#(
  parameter int unsigned N   = 16,
  parameter int unsigned SEG = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         ovf
);

  localparam int unsigned STAGES = calc_stages(N, SEG);

  if (!seg_fits(N, SEG)) begin : g_bad_seg
    $error("pipe_adder_seg: N must be a non-zero multiple of SEG");
  end

  logic              adv;
  logic [N-1:0]      b_eff;
  logic              c0;

  // Operands as seen at the input of each stage.
  logic [N-1:0]      op_a_in  [STAGES];
  logic [N-1:0]      op_b_in  [STAGES];
  logic [STAGES-1:0] stage_cin;
  logic [STAGES-1:0] stage_vin;

  logic [STAGES-1:0] stage_v;
  logic [STAGES-1:0] stage_c;
  logic [SEG-1:0]    stage_s  [STAGES];

  // Skew registers travelling alongside stage k: operands of the beat held in stage k,
  // and result segments 0..k-1 already resolved for it.
  logic [N-1:0]      op_a_d   [STAGES];
  logic [N-1:0]      op_a_q   [STAGES];
  logic [N-1:0]      op_b_d   [STAGES];
  logic [N-1:0]      op_b_q   [STAGES];
  logic [N-1:0]      lo_d     [STAGES];
  logic [N-1:0]      lo_q     [STAGES];
  logic [N-1:0]      res_w    [STAGES];

  logic [N-1:0]      sum_raw;
  logic              a_msb;
  logic              b_msb;

  // Global stall: everything shifts together or nothing moves.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  assign b_eff = (op_e'(sub) == OpSub) ? ~b : b;
  assign c0    = (op_e'(sub) == OpSub) ? ~cin : cin;

  always_comb begin
    op_a_in[0]   = a;
    op_b_in[0]   = b_eff;
    stage_cin[0] = c0;
    stage_vin[0] = in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      op_a_in[k]   = op_a_q[k-1];
      op_b_in[k]   = op_b_q[k-1];
      stage_cin[k] = stage_c[k-1];
      stage_vin[k] = stage_v[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_seg_stage #(
      .SEG(SEG)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .en       (adv),
      .valid_in (stage_vin[k]),
      .a_seg    (op_a_in[k][k*SEG +: SEG]),
      .b_seg    (op_b_in[k][k*SEG +: SEG]),
      .c_in     (stage_cin[k]),
      .valid_out(stage_v[k]),
      .s_seg    (stage_s[k]),
      .c_out    (stage_c[k])
    );
  end

  // Partial result after stage k: earlier segments from the skew register, segment k fresh.
  // lo_q[0] is never loaded, so res_w[0] starts from zero.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      res_w[k]                = lo_q[k];
      res_w[k][k*SEG +: SEG]  = stage_s[k];
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      op_a_d[k] = op_a_q[k];
      op_b_d[k] = op_b_q[k];
      lo_d[k]   = lo_q[k];
    end
    if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        op_a_d[k] = op_a_in[k];
        op_b_d[k] = op_b_in[k];
      end
      lo_d[0] = '0;
      for (int unsigned k = 1; k < STAGES; k++) begin
        lo_d[k] = res_w[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        op_a_q[k] <= '0;
        op_b_q[k] <= '0;
        lo_q[k]   <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        op_a_q[k] <= op_a_d[k];
        op_b_q[k] <= op_b_d[k];
        lo_q[k]   <= lo_d[k];
      end
    end
  end

  assign out_valid = stage_v[STAGES-1];
  assign sum_raw   = res_w[STAGES-1];
  assign c_out     = stage_c[STAGES-1];

  // Overflow uses the effective operand signs and the unsaturated result.
  assign a_msb = op_a_q[STAGES-1][N-1];
  assign b_msb = op_b_q[STAGES-1][N-1];
  assign ovf   = (a_msb == b_msb) & (sum_raw[N-1] != a_msb);

`ifdef PIPE_ADDER_SAT_EN
  // The operation type must follow the beat to the last stage to pick the saturation rail.
  logic [STAGES-1:0] sub_d, sub_q;

  always_comb begin
    sub_d = sub_q;
    if (adv) begin
      sub_d[0] = sub;
      for (int unsigned k = 1; k < STAGES; k++) begin
        sub_d[k] = sub_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sub_q <= '0;
    end else begin
      sub_q <= sub_d;
    end
  end

  always_comb begin
    sum = sum_raw;
    if (op_e'(sub_q[STAGES-1]) == OpSub) begin
      if (!c_out) begin
        sum = '0;
      end
    end else if (c_out) begin
      sum = '1;
    end
  end
`else
  always_comb begin
    sum = sum_raw;
  end
`endif

endmodule

// File: tb/tb_pipe_adder_seg.sv
module tb_pipe_adder_seg;

  localparam int unsigned N   = 16;
  localparam int unsigned SEG = 4;
  localparam int unsigned S   = N / SEG;

`ifdef PIPE_ADDER_SAT_EN
  localparam bit SatOn = 1'b1;
`else
  localparam bit SatOn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [N-1:0] a, b, sum;
  logic         cin, sub;
  logic         out_valid, out_ready;
  logic         c_out, ovf;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] sum;
    logic        c;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    res_t        exp;
  } vec_t;

  // Expected-result model: beats in flight, indexed by how far they have travelled.
  bit   m_v [S];
  res_t m_r [S];

  always #5 clk = ~clk;

  pipe_adder_seg #(
    .N  (N),
    .SEG(SEG)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .c_out    (c_out),
    .ovf      (ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference from the plain integer meaning of the operation.
  function automatic res_t ref_model(logic [15:0] x, logic [15:0] y, logic ci, logic op);
    res_t r;
    int ux = int'(x);
    int uy = int'(y);
    int sx = int'($signed(x));
    int sy = int'($signed(y));
    int total;
    int stot;
    if (!op) begin
      total = ux + uy + int'(ci);
      r.c   = (total > 65535);
      stot  = sx + sy + int'(ci);
    end else begin
      total = ux - uy - int'(ci);
      r.c   = (ux >= uy + int'(ci));
      stot  = sx - sy - int'(ci);
    end
    r.sum = total[15:0];
    r.ovf = (stot > 32767) || (stot < -32768);
    if (SatOn && !op && r.c) r.sum = 16'hFFFF;
    if (SatOn && op && !r.c) r.sum = 16'h0000;
    return r;
  endfunction

  function automatic vec_t mk(logic [15:0] x, logic [15:0] y, logic ci, logic op,
                              logic [15:0] s_wrap, logic [15:0] s_sat, logic c, logic o);
    vec_t v;
    v.a       = x;
    v.b       = y;
    v.cin     = ci;
    v.sub     = op;
    v.exp.sum = SatOn ? s_sat : s_wrap;
    v.exp.c   = c;
    v.exp.ovf = o;
    return v;
  endfunction

  // One clock: check outputs against the model just before the edge, then advance the model.
  task automatic step(output bit acc, output bit got);
    bit adv_m;
    #1;
    check("out_valid", 32'(out_valid), 32'(m_v[S-1]));
    check("in_ready", 32'(in_ready), 32'(!m_v[S-1] || out_ready));
    if (m_v[S-1]) begin
      check("sum", 32'(sum), 32'(m_r[S-1].sum));
      check("c_out", 32'(c_out), 32'(m_r[S-1].c));
      check("ovf", 32'(ovf), 32'(m_r[S-1].ovf));
    end
    adv_m = !m_v[S-1] || out_ready;
    acc   = in_valid && adv_m;
    got   = m_v[S-1] && out_ready;
    @(posedge clk);
    if (adv_m) begin
      for (int k = S - 1; k > 0; k--) begin
        m_v[k] = m_v[k-1];
        m_r[k] = m_r[k-1];
      end
      m_v[0] = in_valid;
      m_r[0] = ref_model(a, b, cin, sub);
    end
    #1;
  endtask

  // Single beat in an empty pipe: must be accepted and emerge exactly S cycles later.
  task automatic run_vec(input vec_t v, input string tag);
    bit acc, got;
    int lat;
    a         = v.a;
    b         = v.b;
    cin       = v.cin;
    sub       = v.sub;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step(acc, got);
    check({tag, "_accept"}, 32'(acc), 32'd1);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      step(acc, got);
      lat++;
    end
    check({tag, "_latency"}, lat, S);
    check({tag, "_sum"}, 32'(sum), 32'(v.exp.sum));
    check({tag, "_cout"}, 32'(c_out), 32'(v.exp.c));
    check({tag, "_ovf"}, 32'(ovf), 32'(v.exp.ovf));
    step(acc, got);
  endtask

  vec_t        tbl [10];
  logic [15:0] ra [8];
  logic [15:0] rb [8];
  logic        rc [8];
  logic        rs [8];
  bit          acc, got;
  int          sent, rcvd, cyc;

  initial begin
    tbl[0] = mk(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 16'h0100, 1'b0, 1'b0);
    tbl[1] = mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
    tbl[2] = mk(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 16'h0000, 1'b0, 1'b0);
    tbl[3] = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 16'h8000, 1'b0, 1'b1);
    tbl[4] = mk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1);
    tbl[5] = mk(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    tbl[6] = mk(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
    tbl[7] = mk(16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0);
    tbl[8] = mk(16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    tbl[9] = mk(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b1);

    for (int k = 0; k < S; k++) m_v[k] = 1'b0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;

    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(c_out), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Back-to-back burst against an alternating out_ready
    for (int i = 0; i < 8; i++) begin
      ra[i] = 16'($urandom);
      rb[i] = 16'($urandom);
      rc[i] = 1'($urandom);
      rs[i] = 1'($urandom);
    end
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    while ((sent < 8 || rcvd < 8) && cyc < 60) begin
      out_ready = (cyc % 2 == 0);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        a   = ra[sent];
        b   = rb[sent];
        cin = rc[sent];
        sub = rs[sent];
      end
      step(acc, got);
      if (acc) sent++;
      if (got) rcvd++;
      cyc++;
    end
    check("burst_sent", sent, 8);
    check("burst_rcvd", rcvd, 8);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < S + 1; i++) step(acc, got);

    // Randomised traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      a         = 16'($urandom);
      b         = 16'($urandom);
      cin       = 1'($urandom);
      sub       = 1'($urandom);
      step(acc, got);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < S + 2; i++) step(acc, got);

    // Reset in the middle of a cycle with the pipe full
    for (int i = 0; i < S; i++) begin
      a         = 16'h1111 * 16'(i + 1);
      b         = 16'h0101;
      cin       = 1'b1;
      sub       = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step(acc, got);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_cout", 32'(c_out), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < S; k++) m_v[k] = 1'b0;
    @(posedge clk);
    #2;
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step(acc, got);
    run_vec(tbl[0], "post_rst");
    for (int i = 0; i < S + 2; i++) step(acc, got);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
